// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/done handshake and result bundle for bin2bcd_seq
interface bin2bcd_seq_if #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [DATA_W-1:0]     data;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic                  overflow;

  modport master (
    output start, data,
    input  busy, done, bcd, sign, overflow
  );

  modport slave (
    input  start, data,
    output busy, done, bcd, sign, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter
module bin2bcd_seq #(
  parameter int DATA_W    = 20,
  parameter int DIGITS    = 6,
  parameter int SIGNED_EN = 0
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  bin2bcd_seq_if.slave       bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADJ  = 2'd1,
    S_SHF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [BCD_W-1:0]   r_bcd_sh;
  logic [DATA_W-1:0]  r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_neg;

  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_ovf_out;
  logic               r_sign_out;

  logic               w_load;
  logic               w_adj;
  logic               w_shf;
  logic               w_finish;
  logic               w_neg;
  logic [DATA_W-1:0]  w_mag;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_shf_bcd;
  logic [DATA_W-1:0]  w_shf_bin;
  logic               w_shf_ovf;

  // W-bit negation is exact even for the most negative value: 2**(W-1) fits unsigned.
  assign w_neg = (SIGNED_EN != 0) && bus.data[DATA_W-1];
  assign w_mag = w_neg ? ((~bus.data) + DATA_W'(1)) : bus.data;

  always_comb begin
    w_bcd_adj = r_bcd_sh;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd_sh[4*k +: 4] > 4'd4) begin
        w_bcd_adj[4*k +: 4] = r_bcd_sh[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_shf_bcd = {r_bcd_sh[BCD_W-2:0], r_bin[DATA_W-1]};
  assign w_shf_bin = {r_bin[DATA_W-2:0], 1'b0};
  assign w_shf_ovf = r_ovf | r_bcd_sh[BCD_W-1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adj       = 1'b0;
    w_shf       = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_ADJ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADJ: begin
        w_adj       = 1'b1;
        w_state_nxt = S_SHF;
      end
      S_SHF: begin
        w_shf = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ADJ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_bcd_sh <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_load) begin
      r_bcd_sh <= '0;
      r_bin    <= w_mag;
      r_cnt    <= CNT_W'(DATA_W);
      r_ovf    <= 1'b0;
      r_neg    <= w_neg;
    end else if (w_adj) begin
      r_bcd_sh <= w_bcd_adj;
    end else if (w_shf) begin
      r_bcd_sh <= w_shf_bcd;
      r_bin    <= w_shf_bin;
      r_ovf    <= w_shf_ovf;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  // Results take the final shift directly so they are valid on the DONE entry edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_bcd_out  <= '0;
      r_ovf_out  <= 1'b0;
      r_sign_out <= 1'b0;
    end else if (w_finish) begin
      r_bcd_out  <= w_shf_ovf ? ALL_NINES : w_shf_bcd;
      r_ovf_out  <= w_shf_ovf;
      r_sign_out <= r_neg;
    end
  end

  assign bus.busy     = (r_state == S_ADJ) || (r_state == S_SHF);
  assign bus.done     = (r_state == S_DONE);
  assign bus.bcd      = r_bcd_out;
  assign bus.overflow = r_ovf_out;
  assign bus.sign     = r_sign_out;

endmodule
